fire_expand3_ofm_writer: RTL and testbench

Downstream stage of the fire4/fire5 expand-3x3 convolution. On each output-pixel sample strobe it captures the 128 parallel, ReLU-clamped channel results and serializes them into the concatenated fire-output RAM, one 16-bit word per cycle. Words are written into the upper half of each pixel's 256-channel slot; the expand-1x1 results occupy the lower half. After the last pixel it raises the RAM-feedback pulse and a done level back to the layer controller.

---
 rtl/fire_expand3_ofm_writer.sv | 165 ++++++++++++++++
 tb/tb_fire_expand3_ofm_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_expand3_ofm_writer.sv
// Serializes the 128 expand-3x3 channel results of each output pixel into the
// upper half of that pixel's slot in the concatenated fire-output RAM.
module fire_expand3_ofm_writer #(
  parameter int DSP_NO    = 128,
  parameter int WIDTH     = 16,
  parameter int WOUT      = 32,
  parameter int CH_TOTAL  = 256,
  parameter int CH_OFFSET = 128,
  parameter int ADDR_W    = $clog2(WOUT * WOUT * CH_TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_en,
  input  logic              sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              busy,
  output logic              ram_feedback,
  output logic              done,
  output logic              overflow
);

  localparam int NPIX  = WOUT * WOUT;
  localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  // One extra count so pix_cnt can hold NPIX after the final burst without wrapping.
  localparam int PIX_W = $clog2(NPIX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic               ram_feedback_q, ram_feedback_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH-1:0]   cap_q [0:DSP_NO-1];
  logic [WIDTH-1:0]   cap_d [0:DSP_NO-1];

  logic               start_burst;
  logic [PIX_W-1:0]   start_pix;
  logic [PIX_W-1:0]   pix_next;
  logic [CH_W-1:0]    ch_next;
  logic               last_ch;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [PIX_W-1:0] pix);
    return ADDR_W'(pix) * ADDR_W'(CH_TOTAL) + ADDR_W'(CH_OFFSET);
  endfunction

  assign pix_next = pix_cnt_q + PIX_W'(1);
  assign ch_next  = ch_cnt_q + CH_W'(1);
  assign last_ch  = (ch_cnt_q == CH_W'(DSP_NO - 1));

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    ch_cnt_d       = ch_cnt_q;
    ram_we_d       = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ram_feedback_d = 1'b0;
    done_d         = done_q;
    overflow_d     = overflow_q;
    cap_d          = cap_q;
    start_burst    = 1'b0;
    start_pix      = pix_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (sample && layer_en) start_burst = 1'b1;
      end

      S_WRITE: begin
        if (!last_ch) begin
          ram_we_d    = 1'b1;
          ch_cnt_d    = ch_next;
          ram_addr_d  = ram_addr_q + ADDR_W'(1);
          ram_wdata_d = cap_q[ch_next];
          if (sample) overflow_d = 1'b1;
        end else begin
          // Last word is on the bus: a sample now can chain the next pixel.
          pix_cnt_d = pix_next;
          if (pix_cnt_q == PIX_W'(NPIX - 1)) begin
            state_d        = S_DONE;
            done_d         = 1'b1;
            ram_feedback_d = 1'b1;
            if (sample) overflow_d = 1'b1;
          end else if (sample && layer_en) begin
            start_burst = 1'b1;
            start_pix   = pix_next;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        if (sample) overflow_d = 1'b1;
        if (!layer_en) begin
          pix_cnt_d = '0;
          done_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start_burst) begin
      cap_d       = ofm;
      ch_cnt_d    = '0;
      ram_we_d    = 1'b1;
      ram_addr_d  = slot_base(start_pix);
      ram_wdata_d = ofm[0];
      state_d     = S_WRITE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      ch_cnt_q       <= '0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_feedback_q <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      ch_cnt_q       <= ch_cnt_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      ram_feedback_q <= ram_feedback_d;
      done_q         <= done_d;
      overflow_q     <= overflow_d;
    end
  end

  // NOTE: the capture bank is pure data qualified by state, so it is left
  // unreset; that keeps it mappable to plain registers or RAM.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = ram_we_q;
  assign ram_feedback = ram_feedback_q;
  assign done         = done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fire_expand3_ofm_writer.sv
// Directed bench for fire_expand3_ofm_writer; a 4x4 output map keeps the
// full-layer run short while exercising the same end-of-layer logic.
module tb_fire_expand3_ofm_writer;

  localparam int DSP_NO = 128;
  localparam int WIDTH  = 16;
  localparam int WOUT   = 4;
  localparam int NPIX   = WOUT * WOUT;
  localparam int ADDR_W = $clog2(NPIX * 256);

  logic              clk = 1'b0;
  logic              rst;
  logic              layer_en;
  logic              sample;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              busy;
  logic              ram_feedback;
  logic              done;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  fire_expand3_ofm_writer #(
    .DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT),
    .CH_TOTAL(256), .CH_OFFSET(128), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .layer_en(layer_en), .sample(sample), .ofm(ofm),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
    .ram_feedback(ram_feedback), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Outputs are observed 1 ns after the edge that updated them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ofm(input int base);
    for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(base + i);
  endtask

  task automatic do_reset();
    rst = 1'b1; layer_en = 1'b0; sample = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({ram_we, busy, ram_feedback, done, overflow} !== 5'b0 ||
        ram_addr !== '0 || ram_wdata !== '0) begin
      errors++;
      $display("FAIL %s: we=%b busy=%b fb=%b done=%b ovf=%b addr=%0d wdata=%0d, need all zero",
               name, ram_we, busy, ram_feedback, done, overflow, ram_addr, ram_wdata);
    end
  endtask

  // Checks one write cycle: enable, busy, address and data.
  task automatic check_write(input string name, input int addr, input int data);
    checks++;
    if (ram_we !== 1'b1 || busy !== 1'b1 || ram_addr !== ADDR_W'(addr) ||
        ram_wdata !== WIDTH'(data)) begin
      errors++;
      $display("FAIL %s: we=%b busy=%b addr=%0d wdata=%0d, need we=1 busy=1 addr=%0d wdata=%0d",
               name, ram_we, busy, ram_addr, ram_wdata, addr, data);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_state");
  endtask

  task automatic test_single_pixel();
    do_reset();
    layer_en = 1'b1;
    load_ofm(1);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    load_ofm(16'h7000);
    for (int k = 0; k < DSP_NO; k++) begin
      check_write("single_write", 128 + k, k + 1);
      tick();
    end
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_end: we=%b busy=%b ovf=%b, need 0 0 0", ram_we, busy, overflow);
    end
  endtask

  task automatic test_gated_sample();
    int writes;
    do_reset();
    load_ofm(5);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    writes = 0;
    for (int k = 0; k < 6; k++) begin
      if (ram_we) writes++;
      tick();
    end
    checks++;
    if (writes != 0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL gated_sample: writes=%0d ovf=%b, need 0 and 0", writes, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    layer_en = 1'b1;
    load_ofm(1);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    for (int k = 0; k < DSP_NO; k++) begin
      check_write("b2b_burst0", 128 + k, k + 1);
      if (k == DSP_NO - 1) begin
        load_ofm(1001);
        sample = 1'b1;
      end
      tick();
    end
    sample = 1'b0;
    load_ofm(16'h5000);
    for (int k = 0; k < DSP_NO; k++) begin
      check_write("b2b_burst1", 384 + k, 1001 + k);
      tick();
    end
    checks++;
    if (ram_we !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: we=%b ovf=%b, need 0 0", ram_we, overflow);
    end
  endtask

  task automatic test_early_sample_dropped();
    int writes;
    do_reset();
    layer_en = 1'b1;
    load_ofm(1);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    for (int k = 0; k < DSP_NO; k++) begin
      check_write("early_burst0", 128 + k, k + 1);
      if (k == DSP_NO - 2) begin
        load_ofm(2001);
        sample = 1'b1;
      end
      tick();
      sample = 1'b0;
    end
    writes = 0;
    for (int k = 0; k < 8; k++) begin
      if (ram_we) writes++;
      tick();
    end
    checks++;
    if (writes != 0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL early_sample: writes=%0d ovf=%b, need 0 and 1", writes, overflow);
    end
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    layer_en = 1'b1;
    load_ofm(1);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    for (int k = 0; k < 50; k++) tick();
    check_write("mid_rst_ch50", 178, 51);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid_rst_outputs");
    tick();
    check_idle_outputs("mid_rst_no_resume");
    load_ofm(300);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    check_write("mid_rst_restart0", 128, 300);
    tick();
    check_write("mid_rst_restart1", 129, 301);
  endtask

  task automatic test_full_layer();
    int we_cnt;
    int fb_cnt;
    do_reset();
    layer_en = 1'b1;
    we_cnt = 0;
    fb_cnt = 0;
    for (int p = 0; p < NPIX; p++) begin
      load_ofm(p * 256);
      sample = 1'b1;
      tick();
      sample = 1'b0;
      for (int j = 0; j < 140; j++) begin
        if (ram_we) we_cnt++;
        if (ram_feedback) fb_cnt++;
        if (j == 0 || j == DSP_NO - 1)
          check_write("layer_write", p * 256 + 128 + j, p * 256 + j);
        if (j == DSP_NO && p < NPIX - 1) begin
          checks++;
          if (done !== 1'b0 || ram_feedback !== 1'b0) begin
            errors++;
            $display("FAIL layer_early_done: pix=%0d done=%b fb=%b, need 0 0", p, done, ram_feedback);
          end
        end
        if (j == DSP_NO && p == NPIX - 1) begin
          checks++;
          if (ram_feedback !== 1'b1 || done !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL layer_feedback: fb=%b done=%b we=%b, need 1 1 0", ram_feedback, done, ram_we);
          end
        end
        tick();
      end
    end
    checks++;
    if (we_cnt != NPIX * DSP_NO || fb_cnt != 1 || done !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL layer_totals: writes=%0d fb=%0d done=%b ovf=%b, need %0d 1 1 0",
               we_cnt, fb_cnt, done, overflow, NPIX * DSP_NO);
    end
  endtask

  // Runs directly after test_full_layer, with the block sitting in DONE.
  task automatic test_layer_rearm();
    load_ofm(900);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    checks++;
    if (overflow !== 1'b1 || done !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rearm_done_sample: ovf=%b done=%b we=%b, need 1 1 0", overflow, done, ram_we);
    end
    layer_en = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rearm_drop: done=%b we=%b, need 0 0", done, ram_we);
    end
    layer_en = 1'b1;
    load_ofm(40);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    check_write("rearm_first", 128, 40);
    tick();
    check_write("rearm_second", 129, 41);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL rearm_sticky_ovf: ovf=%b, need 1", overflow);
    end
  endtask

  initial begin
    rst = 1'b1; layer_en = 1'b0; sample = 1'b0;
    load_ofm(0);
    test_reset();
    test_single_pixel();
    test_gated_sample();
    test_back_to_back();
    test_early_sample_dropped();
    test_mid_burst_reset();
    test_full_layer();
    test_layer_rearm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
